// File: rtl/mrd_pkg.sv
// mrd_pkg: shared types and headroom helpers for the mixed-radix BFP frame buffer
package mrd_pkg;
  localparam int DW = 18;
  localparam int LANES = 5;
  typedef logic [DW-1:0] sample_t;
  typedef struct packed {
    sample_t re;
    sample_t im;
  } cplx_lane_t;
  typedef logic [1:0] margin_t;
  typedef enum logic { W_IDLE, W_FILL } wr_state_t;
  typedef enum logic { R_IDLE, R_RUN } rd_state_t;
  function automatic logic [2:0] lane_flags(input sample_t x);
    return {x[DW-2], x[DW-3], x[DW-4]} ^ {3{x[DW-1]}};
  endfunction
  function automatic margin_t flags_to_margin(input logic [2:0] f);
    return f[2] ? 2'd0 : f[1] ? 2'd1 : f[0] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/mrd_bfp_bank_ram.sv
// mrd_bfp_bank_ram: simple dual-port RAM with registered read data (1-cycle latency)
module mrd_bfp_bank_ram #(
  parameter int W = 180,
  parameter int DEPTH = 24,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/mrd_bfp_frame_buf.sv
// mrd_bfp_frame_buf: ping-pong BFP frame buffer tracking per-frame headroom between radix stages
module mrd_bfp_frame_buf #(
  parameter int FRAME_GROUPS = 12,
  parameter int DW = 18,
  parameter int EXPW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_val,
  input  logic                 in_sop,
  output logic                 in_rdy,
  input  logic [0:4][DW-1:0]   din_real,
  input  logic [0:4][DW-1:0]   din_imag,
  input  logic [EXPW-1:0]      exp_in,
  output logic                 out_val,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [0:4][DW-1:0]   dout_real,
  output logic [0:4][DW-1:0]   dout_imag,
  output logic [1:0]           margin_out,
  output logic [EXPW-1:0]      exp_out,
  output logic                 frame_err
);
  import mrd_pkg::*;
  localparam int IW = $clog2(FRAME_GROUPS);
  localparam int AW = $clog2(2 * FRAME_GROUPS);
  localparam int RW = LANES * 2 * DW;
  localparam logic [IW-1:0] LAST = IW'(FRAME_GROUPS - 1);
  wr_state_t wst_q, wst_d;
  rd_state_t rst_q, rst_d;
  logic [IW-1:0] widx_q, widx_d, ridx_q, ridx_d, wi;
  logic wbank_q, wbank_d, rbank_q, rbank_d;
  logic [EXPW-1:0] ecap_q, ecap_d;
  logic [2:0] acc_q, acc_d, grp_flags;
  logic [1:0] full_q, full_d, wr_set, rd_clr;
  margin_t [1:0] smarg_q, smarg_d;
  logic [1:0][EXPW-1:0] sexp_q, sexp_d;
  logic v1_q, v1_d, sop1_q, sop1_d, eop1_q, eop1_d, bank1_q, bank1_d;
  logic out_val_q, out_val_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d, frame_err_q, frame_err_d;
  logic [0:4][DW-1:0] dout_real_q, dout_real_d, dout_imag_q, dout_imag_d;
  margin_t margin_q, margin_d;
  logic [EXPW-1:0] exp_q, exp_d;
  logic acc, we, rd_go;
  logic [AW-1:0] waddr, raddr;
  cplx_lane_t [0:LANES-1] wr_word, rd_word;
  mrd_bfp_bank_ram #(.W(RW), .DEPTH(2 * FRAME_GROUPS), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wr_word),
    .re    (rd_go),
    .raddr (raddr),
    .rdata (rd_word)
  );
  // Banks are never both full except when a frame is queued behind one under read.
  assign in_rdy = ~(full_q[0] & full_q[1]);
  assign acc = in_val & in_rdy;
  always_comb begin
    grp_flags = '0;
    for (int k = 0; k < LANES; k++) begin
      wr_word[k].re = din_real[k];
      wr_word[k].im = din_imag[k];
      grp_flags = grp_flags | lane_flags(din_real[k]) | lane_flags(din_imag[k]);
    end
  end
  always_comb begin
    wst_d = wst_q;
    widx_d = widx_q;
    wbank_d = wbank_q;
    ecap_d = ecap_q;
    acc_d = acc_q;
    smarg_d = smarg_q;
    sexp_d = sexp_q;
    wr_set = '0;
    we = 1'b0;
    frame_err_d = 1'b0;
    wi = in_sop ? '0 : widx_q;
    waddr = wbank_q ? AW'(FRAME_GROUPS) + AW'(wi) : AW'(wi);
    if (acc && in_sop) begin
      we = 1'b1;
      frame_err_d = wst_q == W_FILL;
      wst_d = W_FILL;
      widx_d = IW'(1);
      ecap_d = exp_in;
      acc_d = grp_flags;
    end else if (acc && wst_q == W_IDLE) begin
      frame_err_d = 1'b1;
    end else if (acc) begin
      we = 1'b1;
      widx_d = widx_q + IW'(1);
      acc_d = acc_q | grp_flags;
      if (widx_q == LAST) begin
        wst_d = W_IDLE;
        widx_d = '0;
        wbank_d = ~wbank_q;
        wr_set[wbank_q] = 1'b1;
        smarg_d[wbank_q] = flags_to_margin(acc_q | grp_flags);
        sexp_d[wbank_q] = ecap_q;
      end
    end
    rst_d = rst_q;
    ridx_d = ridx_q;
    rbank_d = rbank_q;
    rd_clr = '0;
    // A read starts in the same cycle its bank is seen full, so back-to-back frames leave no gap.
    rd_go = (rst_q == R_RUN) | full_q[rbank_q];
    raddr = rbank_q ? AW'(FRAME_GROUPS) + AW'(ridx_q) : AW'(ridx_q);
    if (rd_go && ridx_q == LAST) begin
      rd_clr[rbank_q] = 1'b1;
      rbank_d = ~rbank_q;
      ridx_d = '0;
      rst_d = R_IDLE;
    end else if (rd_go) begin
      ridx_d = ridx_q + IW'(1);
      rst_d = R_RUN;
    end
    full_d = (full_q & ~rd_clr) | wr_set;
    v1_d = rd_go;
    sop1_d = rd_go & (ridx_q == '0);
    eop1_d = rd_go & (ridx_q == LAST);
    bank1_d = rbank_q;
    out_val_d = v1_q;
    out_sop_d = sop1_q;
    out_eop_d = eop1_q;
    margin_d = sop1_q ? smarg_q[bank1_q] : margin_q;
    exp_d = sop1_q ? sexp_q[bank1_q] : exp_q;
    for (int k = 0; k < LANES; k++) begin
      dout_real_d[k] = v1_q ? rd_word[k].re : dout_real_q[k];
      dout_imag_d[k] = v1_q ? rd_word[k].im : dout_imag_q[k];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wst_q <= W_IDLE;
      rst_q <= R_IDLE;
      widx_q <= '0;
      ridx_q <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      ecap_q <= '0;
      acc_q <= '0;
      full_q <= '0;
      smarg_q <= '0;
      sexp_q <= '0;
      v1_q <= 1'b0;
      sop1_q <= 1'b0;
      eop1_q <= 1'b0;
      bank1_q <= 1'b0;
      out_val_q <= 1'b0;
      out_sop_q <= 1'b0;
      out_eop_q <= 1'b0;
      frame_err_q <= 1'b0;
      dout_real_q <= '0;
      dout_imag_q <= '0;
      margin_q <= '0;
      exp_q <= '0;
    end else begin
      wst_q <= wst_d;
      rst_q <= rst_d;
      widx_q <= widx_d;
      ridx_q <= ridx_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      ecap_q <= ecap_d;
      acc_q <= acc_d;
      full_q <= full_d;
      smarg_q <= smarg_d;
      sexp_q <= sexp_d;
      v1_q <= v1_d;
      sop1_q <= sop1_d;
      eop1_q <= eop1_d;
      bank1_q <= bank1_d;
      out_val_q <= out_val_d;
      out_sop_q <= out_sop_d;
      out_eop_q <= out_eop_d;
      frame_err_q <= frame_err_d;
      dout_real_q <= dout_real_d;
      dout_imag_q <= dout_imag_d;
      margin_q <= margin_d;
      exp_q <= exp_d;
    end
  end
  assign out_val = out_val_q;
  assign out_sop = out_sop_q;
  assign out_eop = out_eop_q;
  assign frame_err = frame_err_q;
  assign dout_real = dout_real_q;
  assign dout_imag = dout_imag_q;
  assign margin_out = margin_q;
  assign exp_out = exp_q;
endmodule

// File: tb/tb_mrd_bfp_frame_buf.sv
// tb_mrd_bfp_frame_buf: directed checks of the BFP frame buffer (12-group and 2-group instances)
module tb_mrd_bfp_frame_buf;
  localparam int FG = 12;
  typedef logic [0:4][17:0] lanes_t;
  typedef struct {
    logic [89:0] re;
    logic [89:0] im;
    logic sop;
    logic eop;
    logic [1:0] m;
    logic [3:0] e;
    int c;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n, in_val, in_val2, in_sop;
  logic [3:0] exp_in;
  lanes_t din_real, din_imag;
  logic in_rdy, out_val, out_sop, out_eop, frame_err;
  lanes_t dout_real, dout_imag;
  logic [1:0] margin_out;
  logic [3:0] exp_out;
  logic in_rdy2, out_val2, out_sop2, out_eop2, frame_err2;
  lanes_t dout_real2, dout_imag2;
  logic [1:0] margin_out2;
  logic [3:0] exp_out2;
  int cyc = 0, n_chk = 0, n_pass = 0, err_cnt = 0, err_cyc = 0, err2_cnt = 0, rdy_miss = 0, t_last = 0;
  int ovr_g = -1;
  logic [17:0] ovr_val = '0;
  beat_t q[$], q2[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mrd_bfp_frame_buf #(.FRAME_GROUPS(FG)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_sop(in_sop), .in_rdy(in_rdy),
    .din_real(din_real), .din_imag(din_imag), .exp_in(exp_in),
    .out_val(out_val), .out_sop(out_sop), .out_eop(out_eop),
    .dout_real(dout_real), .dout_imag(dout_imag),
    .margin_out(margin_out), .exp_out(exp_out), .frame_err(frame_err)
  );
  mrd_bfp_frame_buf #(.FRAME_GROUPS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_val(in_val2), .in_sop(in_sop), .in_rdy(in_rdy2),
    .din_real(din_real), .din_imag(din_imag), .exp_in(exp_in),
    .out_val(out_val2), .out_sop(out_sop2), .out_eop(out_eop2),
    .dout_real(dout_real2), .dout_imag(dout_imag2),
    .margin_out(margin_out2), .exp_out(exp_out2), .frame_err(frame_err2)
  );
  always @(negedge clk) begin
    if (out_val === 1'b1) q.push_back('{dout_real, dout_imag, out_sop, out_eop, margin_out, exp_out, cyc});
    if (out_val2 === 1'b1) q2.push_back('{dout_real2, dout_imag2, out_sop2, out_eop2, margin_out2, exp_out2, cyc});
    if (frame_err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (frame_err2 === 1'b1) err2_cnt++;
  end
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask
  function automatic lanes_t lanes(input int seed, input int g, input bit im);
    lanes_t v;
    for (int k = 0; k < 5; k++) v[k] = 18'(seed * 512 + g * 16 + k + (im ? 128 : 0));
    if (!im && g == ovr_g) v[2] = ovr_val;
    return v;
  endfunction
  task automatic put(input bit sel, input logic v, input logic s, input int seed, input int g, input logic [3:0] e);
    @(posedge clk);
    #1;
    in_val = v & !sel;
    in_val2 = v & sel;
    in_sop = s;
    exp_in = e;
    din_real = lanes(seed, g, 0);
    din_imag = lanes(seed, g, 1);
    if (v && !(sel ? in_rdy2 : in_rdy)) rdy_miss++;
    t_last = cyc;
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
    in_val = 1'b0;
    in_val2 = 1'b0;
    in_sop = 1'b0;
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input bit sel, input int nb, input int seed, input logic [3:0] e);
    for (int g = 0; g < nb; g++) put(sel, 1'b1, g == 0, seed, g, e);
  endtask
  task automatic check_frame(input string tag, input bit sel, input int nb, input int seed,
                             input logic [3:0] e, input logic [1:0] m, input int start);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      if ((sel ? q2.size() : q.size()) == 0) break;
      b = sel ? q2.pop_front() : q.pop_front();
      chk($sformatf("%s re%0d", tag, i), b.re, lanes(seed, i, 0));
      chk($sformatf("%s im%0d", tag, i), b.im, lanes(seed, i, 1));
      chk($sformatf("%s sop%0d", tag, i), b.sop, i == 0);
      chk($sformatf("%s eop%0d", tag, i), b.eop, i == nb - 1);
      chk($sformatf("%s margin%0d", tag, i), b.m, m);
      chk($sformatf("%s exp%0d", tag, i), b.e, e);
      chk($sformatf("%s cycle%0d", tag, i), b.c, start + i);
    end
  endtask
  task automatic margin_case(input string tag, input logic [17:0] val, input logic [1:0] m, input logic [3:0] e);
    int t;
    ovr_g = 3;
    ovr_val = val;
    send_frame(0, FG, 2, e);
    t = t_last;
    idle();
    wait_cyc(20);
    chk({tag, " beats"}, q.size(), FG);
    check_frame(tag, 0, FG, 2, e, m, t + 3);
    ovr_g = -1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int t, k, tf[6];
    in_val = 1'b0;
    in_val2 = 1'b0;
    in_sop = 1'b0;
    exp_in = '0;
    din_real = '0;
    din_imag = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cyc(1);
    chk("rst out_val", out_val, 1'b0);
    chk("rst out_sop", out_sop, 1'b0);
    chk("rst out_eop", out_eop, 1'b0);
    chk("rst frame_err", frame_err, 1'b0);
    chk("rst margin", margin_out, 2'd0);
    chk("rst exp", exp_out, 4'd0);
    chk("rst dout_real", dout_real, 90'd0);
    chk("rst dout_imag", dout_imag, 90'd0);
    chk("rst in_rdy", in_rdy, 1'b1);
    send_frame(0, FG, 1, 4'd5);
    t = t_last;
    idle();
    wait_cyc(20);
    chk("single beats", q.size(), FG);
    check_frame("single", 0, FG, 1, 4'd5, 2'd3, t + 3);
    margin_case("m0", 18'h20000, 2'd0, 4'd7);
    margin_case("m1", 18'h0C000, 2'd1, 4'd8);
    margin_case("m2", 18'h06000, 2'd2, 4'd9);
    margin_case("m3neg", 18'h3C000, 2'd3, 4'd6);
    rdy_miss = 0;
    send_frame(0, FG, 2, 4'd1);
    tf[0] = t_last;
    send_frame(0, FG, 3, 4'd2);
    tf[1] = t_last;
    send_frame(0, FG, 4, 4'd3);
    tf[2] = t_last;
    idle();
    wait_cyc(30);
    chk("b2b in_rdy misses", rdy_miss, 0);
    chk("b2b beats", q.size(), 3 * FG);
    check_frame("b2b f0", 0, FG, 2, 4'd1, 2'd3, tf[0] + 3);
    check_frame("b2b f1", 0, FG, 3, 4'd2, 2'd3, tf[1] + 3);
    check_frame("b2b f2", 0, FG, 4, 4'd3, 2'd3, tf[2] + 3);
    err_cnt = 0;
    for (int g = 0; g < 5; g++) put(0, 1'b1, g == 0, 5, g, 4'd9);
    put(0, 1'b1, 1'b1, 6, 0, 4'd10);
    k = t_last;
    for (int g = 1; g < FG; g++) put(0, 1'b1, 1'b0, 6, g, 4'd10);
    t = t_last;
    idle();
    wait_cyc(20);
    chk("restart err count", err_cnt, 1);
    chk("restart err cycle", err_cyc, k + 1);
    chk("restart beats", q.size(), FG);
    check_frame("restart", 0, FG, 6, 4'd10, 2'd3, t + 3);
    err_cnt = 0;
    put(0, 1'b1, 1'b0, 7, 0, 4'd3);
    k = t_last;
    idle();
    wait_cyc(20);
    chk("stray err count", err_cnt, 1);
    chk("stray err cycle", err_cyc, k + 1);
    chk("stray beats", q.size(), 0);
    send_frame(0, FG, 8, 4'd11);
    idle();
    wait_cyc(4);
    chk("midrst started", out_val, 1'b1);
    rst_n = 1'b0;
    wait_cyc(1);
    chk("midrst out_val", out_val, 1'b0);
    chk("midrst out_sop", out_sop, 1'b0);
    chk("midrst out_eop", out_eop, 1'b0);
    chk("midrst margin", margin_out, 2'd0);
    chk("midrst exp", exp_out, 4'd0);
    chk("midrst dout_real", dout_real, 90'd0);
    chk("midrst in_rdy", in_rdy, 1'b1);
    rst_n = 1'b1;
    q.delete();
    q2.delete();
    wait_cyc(30);
    chk("midrst no output", q.size(), 0);
    send_frame(0, FG, 9, 4'd4);
    t = t_last;
    idle();
    wait_cyc(20);
    chk("postrst beats", q.size(), FG);
    check_frame("postrst", 0, FG, 9, 4'd4, 2'd3, t + 3);
    rdy_miss = 0;
    err2_cnt = 0;
    for (int f = 0; f < 6; f++) begin
      send_frame(1, 2, 10 + f, 4'(10 + f));
      tf[f] = t_last;
    end
    idle();
    wait_cyc(20);
    chk("stall in_rdy misses", rdy_miss, 0);
    chk("stall frame_err", err2_cnt, 0);
    chk("stall beats", q2.size(), 12);
    for (int f = 0; f < 6; f++)
      check_frame($sformatf("stall f%0d", f), 1, 2, 10 + f, 4'(10 + f), 2'd3, tf[f] + 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
